dict_codec: RTL and testbench

Parametrised, handshaked successor to the team's dictionary compression/decompression block. It maps DATA_WIDTH-bit words to INDEX_WIDTH-bit dictionary indices (compress) and back (decompress). It uses a multi-lane sequential dictionary search, explicit occupancy tracking (an all-zero word is a legal entry), a flush command, and valid/ready flow control on both the command side and the response side. It sits between the host command interface and the stream packer, replacing the fixed 80-bit, 255-entry single-cycle variant.

---
 rtl/dict_codec_if.sv | 38 +++
 rtl/dict_codec.sv | 207 ++++++++++++++++++++
 tb/tb_dict_codec.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dict_codec_if.sv
// Command/response bus of the dictionary codec.
// Both directions use the same handshake: a transfer happens on a rising clock
// edge where valid && ready are both high. The producer holds valid and its
// payload stable until that edge. Ready may depend on the consumer's state, but
// never on valid.
interface dict_codec_if #(
    parameter int DATA_WIDTH  = 80,
    parameter int INDEX_WIDTH = 8
);
    // Command side (host -> codec)
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             command;
    logic [DATA_WIDTH-1:0]  data_in;
    logic [INDEX_WIDTH-1:0] compressed_in;

    // Response side (codec -> packer)
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             response;
    logic [INDEX_WIDTH-1:0] compressed_out;
    logic [DATA_WIDTH-1:0]  decompressed_out;
    logic                   hit;
    logic [INDEX_WIDTH:0]   occupancy;
    logic                   full;

    modport master (
        output cmd_valid, command, data_in, compressed_in, rsp_ready,
        input  cmd_ready, rsp_valid, response, compressed_out,
               decompressed_out, hit, occupancy, full
    );

    modport slave (
        input  cmd_valid, command, data_in, compressed_in, rsp_ready,
        output cmd_ready, rsp_valid, response, compressed_out,
               decompressed_out, hit, occupancy, full
    );
endinterface

// File: rtl/dict_codec.sv
// Dictionary codec: maps words to dictionary indices (compress) and back
// (decompress). Compress searches LANES entries per cycle. Validity comes only
// from the occupancy count, so an all-zero word is an ordinary entry.
module dict_codec #(
    parameter int DATA_WIDTH  = 80,
    parameter int DEPTH       = 255,
    parameter int INDEX_WIDTH = 8,
    parameter int LANES       = 4
) (
    input  logic         clk,
    input  logic         reset,       // asynchronous, active low
    dict_codec_if.slave  bus,
    output logic [1:0]   o_dbg_state  // 0 IDLE, 1 SEARCH, 2 RESP
);
    localparam int OCC_W  = INDEX_WIDTH + 1;
    // Search base can step up to one LANES stride past DEPTH, so it needs headroom.
    localparam int BASE_W = INDEX_WIDTH + 2;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    localparam logic [1:0] CMD_COMP   = 2'b01;
    localparam logic [1:0] CMD_DECOMP = 2'b10;
    localparam logic [1:0] CMD_FLUSH  = 2'b11;

    localparam logic [1:0] RSP_ACK    = 2'b00;
    localparam logic [1:0] RSP_COMP   = 2'b01;
    localparam logic [1:0] RSP_DECOMP = 2'b10;
    localparam logic [1:0] RSP_ERR    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                 r_state, w_next_state;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]  r_data;
    logic [BASE_W-1:0]      r_base, w_base_next, w_lane_addr;
    logic [OCC_W-1:0]       r_occ, w_occ_next;
    logic                   r_full;
    logic [INDEX_WIDTH-1:0] r_comp, w_comp_val;
    logic                   r_hit, w_hit_val, w_upd_comp;
    logic [DATA_WIDTH-1:0]  r_dec, w_dec_val;
    logic                   w_upd_dec;
    logic [1:0]             r_resp, w_resp_val;
    logic                   w_mem_we;
    logic [DATA_WIDTH-1:0]  w_mem_wdata;
    logic                   w_match;
    logic [INDEX_WIDTH-1:0] w_match_idx;
    logic                   w_accept;

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;

    // Compare the current window of LANES entries; keep the lowest valid match.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_lane_addr = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            w_lane_addr = r_base + BASE_W'(l);
            if ((w_lane_addr < BASE_W'(r_occ)) &&
                (r_mem[w_lane_addr[INDEX_WIDTH-1:0]] == r_data)) begin
                w_match     = 1'b1;
                w_match_idx = w_lane_addr[INDEX_WIDTH-1:0];
            end
        end
    end

    // Next state plus the dictionary/result updates made on the edge entering RESP.
    always_comb begin
        w_next_state = r_state;
        w_base_next  = r_base;
        w_occ_next   = r_occ;
        w_mem_we     = 1'b0;
        w_mem_wdata  = r_data;
        w_upd_comp   = 1'b0;
        w_comp_val   = r_comp;
        w_hit_val    = r_hit;
        w_upd_dec    = 1'b0;
        w_dec_val    = r_dec;
        w_resp_val   = r_resp;
        unique case (r_state)
            ST_IDLE: begin
                w_base_next = '0;
                if (bus.cmd_valid) begin
                    case (bus.command)
                        CMD_COMP: begin
                            if (r_occ == '0) begin
                                // Empty dictionary: a miss with no search needed.
                                w_next_state = ST_RESP;
                                w_mem_we     = 1'b1;
                                w_mem_wdata  = bus.data_in;
                                w_occ_next   = r_occ + OCC_W'(1);
                                w_upd_comp   = 1'b1;
                                w_comp_val   = '0;
                                w_hit_val    = 1'b0;
                                w_resp_val   = RSP_COMP;
                            end else begin
                                w_next_state = ST_SEARCH;
                            end
                        end
                        CMD_DECOMP: begin
                            w_next_state = ST_RESP;
                            w_upd_dec    = 1'b1;
                            if ({1'b0, bus.compressed_in} < r_occ) begin
                                w_dec_val  = r_mem[bus.compressed_in];
                                w_resp_val = RSP_DECOMP;
                            end else begin
                                w_dec_val  = '0;
                                w_resp_val = RSP_ERR;
                            end
                        end
                        CMD_FLUSH: begin
                            w_next_state = ST_RESP;
                            w_occ_next   = '0;
                            w_resp_val   = RSP_ACK;
                        end
                        default: begin
                            w_next_state = ST_RESP;
                            w_resp_val   = RSP_ACK;
                        end
                    endcase
                end
            end
            ST_SEARCH: begin
                w_base_next = r_base + BASE_W'(LANES);
                if (w_match) begin
                    w_next_state = ST_RESP;
                    w_upd_comp   = 1'b1;
                    w_comp_val   = w_match_idx;
                    w_hit_val    = 1'b1;
                    w_resp_val   = RSP_COMP;
                end else if (w_base_next >= BASE_W'(r_occ)) begin
                    // Every valid entry has been compared without a match.
                    w_next_state = ST_RESP;
                    w_upd_comp   = 1'b1;
                    w_hit_val    = 1'b0;
                    if (r_occ == DEPTH_OCC) begin
                        w_comp_val = '0;
                        w_resp_val = RSP_ERR;
                    end else begin
                        w_mem_we   = 1'b1;
                        w_comp_val = r_occ[INDEX_WIDTH-1:0];
                        w_occ_next = r_occ + OCC_W'(1);
                        w_resp_val = RSP_COMP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, occupancy and registered results; reset aborts any command in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_occ   <= '0;
            r_full  <= 1'b0;
            r_data  <= '0;
            r_comp  <= '0;
            r_hit   <= 1'b0;
            r_dec   <= '0;
            r_resp  <= RSP_ACK;
        end else begin
            r_state <= w_next_state;
            r_base  <= w_base_next;
            r_occ   <= w_occ_next;
            r_full  <= (w_occ_next == DEPTH_OCC);
            r_resp  <= w_resp_val;
            if (w_accept) begin
                r_data <= bus.data_in;
            end
            if (w_upd_comp) begin
                r_comp <= w_comp_val;
                r_hit  <= w_hit_val;
            end
            if (w_upd_dec) begin
                r_dec <= w_dec_val;
            end
        end
    end

    // Dictionary storage: appended at the occupancy index, never cleared.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_occ[INDEX_WIDTH-1:0]] <= w_mem_wdata;
        end
    end

    assign bus.cmd_ready        = (r_state == ST_IDLE);
    assign bus.rsp_valid        = (r_state == ST_RESP);
    assign bus.response         = r_resp;
    assign bus.compressed_out   = r_comp;
    assign bus.decompressed_out = r_dec;
    assign bus.hit              = r_hit;
    assign bus.occupancy        = r_occ;
    assign bus.full             = r_full;
    assign o_dbg_state          = r_state;
endmodule

// File: tb/tb_dict_codec.sv
// Directed bench for dict_codec (default parameters, LANES = 4).
module tb_dict_codec;
    localparam int DW = 80;
    localparam int IW = 8;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    dict_codec_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

    dict_codec #(
        .DATA_WIDTH(DW), .DEPTH(255), .INDEX_WIDTH(IW), .LANES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]    g_resp;
    logic [IW-1:0] g_comp;
    logic [DW-1:0] g_dec;
    logic          g_hit;
    int            g_lat;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command from #1 after an edge; return #1 after its acceptance edge.
    task automatic send_only(input logic [1:0] cmd, input logic [DW-1:0] d, input logic [IW-1:0] idx);
        int t;
        bus.command       = cmd;
        bus.data_in       = d;
        bus.compressed_in = idx;
        bus.cmd_valid     = 1'b1;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $error("FAIL accept_timeout: observed cmd_ready %b required 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Count edges from acceptance (edge 1) until rsp_valid; capture the results.
    task automatic wait_rsp();
        g_lat = 1;
        while (bus.rsp_valid !== 1'b1 && g_lat < 300) begin
            @(posedge clk); #1;
            g_lat++;
        end
        if (bus.rsp_valid !== 1'b1) begin
            n_cmp++;
            n_err++;
            $error("FAIL rsp_timeout: observed rsp_valid %b required 1", bus.rsp_valid);
        end
        g_resp = bus.response;
        g_comp = bus.compressed_out;
        g_dec  = bus.decompressed_out;
        g_hit  = bus.hit;
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic [1:0] cmd, input logic [DW-1:0] d, input logic [IW-1:0] idx);
        send_only(cmd, d, idx);
        wait_rsp();
        consume();
    endtask

    task automatic fill(input int n, input int base_val);
        for (int i = 0; i < n; i++) begin
            xact(2'b01, DW'(base_val + i), '0);
        end
    endtask

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.command       = 2'b00;
        bus.data_in       = '0;
        bus.compressed_in = '0;
        bus.rsp_ready     = 1'b0;
        reset             = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_response", bus.response, 0);
        chk("rst_comp", bus.compressed_out, 0);
        chk("rst_dec", bus.decompressed_out, 0);
        chk("rst_hit", bus.hit, 0);
        chk("rst_occ", bus.occupancy, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Zero word is a real entry
        xact(2'b01, 80'h0, '0);
        chk("z_resp", g_resp, 1);
        chk("z_idx", g_comp, 0);
        chk("z_hit", g_hit, 0);
        chk("z_lat", g_lat, 1);
        xact(2'b01, 80'h1, '0);
        chk("one_resp", g_resp, 1);
        chk("one_idx", g_comp, 1);
        chk("one_hit", g_hit, 0);
        chk("one_lat", g_lat, 2);
        chk("one_occ", bus.occupancy, 2);
        xact(2'b01, 80'h0, '0);
        chk("z_again_idx", g_comp, 0);
        chk("z_again_hit", g_hit, 1);

        // Hit deep in the dictionary
        xact(2'b11, '0, '0);
        chk("fl_resp", g_resp, 0);
        chk("fl_occ", bus.occupancy, 0);
        fill(10, 'h100);
        xact(2'b01, 80'h109, '0);
        chk("h9_lat", g_lat, 4);
        chk("h9_idx", g_comp, 9);
        chk("h9_hit", g_hit, 1);
        chk("h9_resp", g_resp, 1);
        chk("h9_occ", bus.occupancy, 10);
        xact(2'b01, 80'h100, '0);
        chk("h0_lat", g_lat, 2);
        chk("h0_idx", g_comp, 0);

        // Decompress in and out of range
        xact(2'b11, '0, '0);
        fill(5, 'h200);
        xact(2'b10, '0, 8'd3);
        chk("d3_resp", g_resp, 2);
        chk("d3_data", g_dec, 'h203);
        chk("d3_lat", g_lat, 1);
        chk("d3_comp_held", g_comp, 4);
        xact(2'b10, '0, 8'd5);
        chk("d5_resp", g_resp, 3);
        chk("d5_data", g_dec, 0);

        // Back-pressure on the response
        send_only(2'b01, 80'h2AB, '0);
        wait_rsp();
        chk("bp_lat", g_lat, 3);
        chk("bp_idx", g_comp, 5);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
            chk("bp_resp", bus.response, 1);
            chk("bp_comp", bus.compressed_out, 5);
        end
        chk("bp_state", dbg_state, 2);
        bus.rsp_ready     = 1'b1;
        bus.command       = 2'b00;
        bus.cmd_valid     = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", bus.cmd_ready, 1);
        chk("bp_release_valid", bus.rsp_valid, 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("nop_valid", bus.rsp_valid, 1);
        chk("nop_resp", bus.response, 0);
        chk("nop_comp_held", bus.compressed_out, 5);
        chk("nop_occ", bus.occupancy, 6);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;

        // Flush a populated dictionary
        xact(2'b11, '0, '0);
        fill(20, 'h300);
        chk("f20_occ", bus.occupancy, 20);
        xact(2'b11, '0, '0);
        chk("f20_resp", g_resp, 0);
        chk("f20_occ_after", bus.occupancy, 0);
        xact(2'b10, '0, 8'd0);
        chk("f20_dec_resp", g_resp, 3);
        chk("f20_dec_data", g_dec, 0);

        // Full dictionary
        fill(255, 'h1000);
        chk("full_occ", bus.occupancy, 255);
        chk("full_flag", bus.full, 1);
        xact(2'b01, 80'hDEAD, '0);
        chk("full_miss_resp", g_resp, 3);
        chk("full_miss_idx", g_comp, 0);
        chk("full_miss_hit", g_hit, 0);
        chk("full_miss_lat", g_lat, 65);
        chk("full_miss_occ", bus.occupancy, 255);
        xact(2'b01, 80'h10C8, '0);
        chk("full_hit_resp", g_resp, 1);
        chk("full_hit_idx", g_comp, 200);
        chk("full_hit_hit", g_hit, 1);
        chk("full_hit_lat", g_lat, 52);
        xact(2'b10, '0, 8'd254);
        chk("d254_resp", g_resp, 2);
        chk("d254_data", g_dec, 'h10FE);
        xact(2'b10, '0, 8'd255);
        chk("d255_resp", g_resp, 3);

        // Reset in the middle of a search
        send_only(2'b01, 80'hBEEF, '0);
        @(posedge clk);
        @(posedge clk); #3;
        chk("mid_state", dbg_state, 1);
        reset = 1'b0;
        #1;
        chk("mid_rsp_valid", bus.rsp_valid, 0);
        chk("mid_occ", bus.occupancy, 0);
        chk("mid_cmd_ready", bus.cmd_ready, 1);
        chk("mid_full", bus.full, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", bus.rsp_valid, 0);
        xact(2'b10, '0, 8'd0);
        chk("post_dec_resp", g_resp, 3);
        xact(2'b01, 80'h55, '0);
        chk("post_comp_idx", g_comp, 0);
        chk("post_comp_hit", g_hit, 0);
        chk("post_comp_occ", bus.occupancy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
